sasa_match_sched: RTL and testbench
===================================

Name: sasa_match_sched

Overview:
- Sequential consumer and driver of the SASA CAM priority stage.
- Accepts one full CAM match vector per transaction and presents the pending vector to the combinational highest-match finder.
- Binary-encodes the returned one-hot, emits one match index per handshake (highest index first) and clears that bit, until no bits remain.
- Feeds the downstream attention/gather logic with a serialized index stream.

Parameters:
- CAM_LEN, 256, match vector width (equals SASA_CAM_len).
- IDX_W, 8, index width, $clog2(CAM_LEN).
- CNT_W, 9, match count width, $clog2(CAM_LEN+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  match vector offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  CAM_LEN  raw OR'd CAM match vector.
- flush  in  1  synchronous abort of the current transaction.
- fm_or_vec  out  CAM_LEN  pending vector driven to the finder.
- fm_lm_vec  in  CAM_LEN  one-hot highest set bit of fm_or_vec, combinational return.
- out_valid  out  1  index beat valid.
- out_ready  in  1  consumer accepts beat.
- out_idx  out  IDX_W  binary index of the current highest pending match.
- out_last  out  1  current beat is the final match of the transaction.
- done  out  1  one-cycle end-of-transaction pulse.
- match_cnt  out  CNT_W  beats issued in the transaction; valid while done=1.
- onehot_err  out  1  sticky finder-consistency error (see Optional Feature).

Behaviour:
- Reset values:
  - state=IDLE, pending=0, count=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, done=0, match_cnt=0, onehot_err=0, fm_or_vec=0.
- fm_or_vec is driven directly from the pending register. The finder is combinational and out_idx, out_last are combinational from fm_lm_vec and pending, so there is no added latency.
- FSM states: IDLE, EMIT, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready: pending<=in_vec, count<=0. If in_vec==0, go to DONE, else go to EMIT.
  - EMIT: out_valid=1, in_ready=0.
    - out_idx = position of the set bit in fm_lm_vec.
    - out_last = ((pending & ~fm_lm_vec)==0).
    - On out_valid&&out_ready: pending<=pending & ~fm_lm_vec and count<=count+1. If out_last, go to DONE.
    - While out_ready=0, hold out_idx/pending stable; no bit is cleared.
  - DONE: done=1 for exactly one cycle, match_cnt=count, in_ready=0. Next state is IDLE.
- Timing:
  - Accept at cycle T gives the first beat at T+1.
  - With out_ready held high, N matches occupy T+1..T+N, done is at T+N+1, and in_ready returns at T+N+2.
  - Zero vector: done at T+1 with match_cnt=0, no beats.
- match_cnt holds its last value outside DONE. count saturates at CAM_LEN; the maximum is an all-ones vector giving 256 beats, 0xFF down to 0x00.
- flush takes priority over every handshake in the same cycle:
  - Next state is IDLE, pending<=0, count<=0, no done pulse.
  - A beat presented in the flush cycle counts as not transferred.
  - in_valid in the flush cycle is ignored.
- Async reset mid-transaction returns all state to reset values immediately.
- Back-to-back transactions: no accept is possible in EMIT or DONE.

Optional Feature:
- Macro: SASA_ONEHOT_CHK_EN.
- Defined: in EMIT, the checker sets onehot_err (sticky) when any of the following holds:
  - fm_lm_vec is not exactly one-hot;
  - fm_lm_vec & ~pending != 0;
  - fm_lm_vec is not the highest set bit of pending.
- onehot_err is cleared only by rst_n or flush. When onehot_err is set, the FSM still progresses as specified.
- Not defined: the checker logic is absent and onehot_err is tied to 0.

Test Plan:
- in_vec bits {200,37,5}, out_ready=1 -> out_idx 200,37,5 on T+1..T+3; out_last only on 5; done at T+4 with match_cnt=3; in_ready=1 at T+5.
- in_vec=0 -> no out_valid; done at T+1 with match_cnt=0.
- in_vec bits {255,0}, out_ready low for 3 cycles on the first beat -> out_idx stays 255 and is not cleared; then 255, 0 issue, match_cnt=2.
- All-ones vector -> 256 beats from 255 down to 0; match_cnt=256; out_last only on idx 0.
- flush asserted during the second beat of {10,9,8} -> state IDLE the next cycle, in_ready=1, no done; a following vector {3} yields idx 3 and match_cnt=1.
- With SASA_ONEHOT_CHK_EN, the bench model forces fm_lm_vec=0x3 while pending=0x3 -> onehot_err=1, held until flush; without the macro, onehot_err stays 0.

Source files
------------

// File: rtl/sasa_match_sched.sv
// sasa_match_sched: drains a CAM match vector one index per handshake,
// highest index first, using an external combinational highest-match finder.
// Optional finder-consistency checker enabled by macro SASA_ONEHOT_CHK_EN;
// without it onehot_err is tied low.
module sasa_match_sched #(
   parameter int unsigned CAM_LEN = 256,
   parameter int unsigned IDX_W   = $clog2(CAM_LEN),
   parameter int unsigned CNT_W   = $clog2(CAM_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CAM_LEN-1:0] in_vec,
   input  logic               flush,
   output logic [CAM_LEN-1:0] fm_or_vec,
   input  logic [CAM_LEN-1:0] fm_lm_vec,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic               done,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               onehot_err
);

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [CAM_LEN-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   match_cnt_q;
   logic [IDX_W-1:0]   lm_idx;
   logic [CAM_LEN-1:0] remain;
   logic               is_last;

   // State, pending vector, beat counter and the held match count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         count_q     <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         if (state_d == DONE) match_cnt_q <= count_d;
      end
   end

   // Pending bits left once the finder's current pick is removed
   always_comb begin
      remain  = pending_q & ~fm_lm_vec;
      is_last = (remain == '0);
   end

   // Next-state logic; flush overrides every handshake in the same cycle
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pending_d = in_vec;
               count_d   = '0;
               state_d   = (in_vec == '0) ? DONE : EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pending_d = remain;
               if (count_q != CNT_W'(CAM_LEN)) count_d = count_q + CNT_W'(1);
               if (is_last) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         pending_d = '0;
         count_d   = '0;
      end
   end

   // OR-encoder of the finder's one-hot return
   always_comb begin
      lm_idx = '0;
      for (int i = 0; i < CAM_LEN; i++) begin
         if (fm_lm_vec[i]) lm_idx = lm_idx | IDX_W'(i);
      end
   end

   // Handshake and beat outputs decoded from the state register
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == EMIT);
      done      = (state_q == DONE);
      out_idx   = out_valid ? lm_idx : '0;
      out_last  = out_valid & is_last;
      fm_or_vec = pending_q;
      match_cnt = match_cnt_q;
   end

`ifdef SASA_ONEHOT_CHK_EN
   logic [CAM_LEN-1:0] top_bit;
   logic               onehot_ok;
   logic               chk_fail;
   logic               err_q;

   // Reference highest set bit of pending and the three consistency checks
   always_comb begin
      top_bit = '0;
      for (int i = 0; i < CAM_LEN; i++) begin
         if (pending_q[i]) begin
            top_bit    = '0;
            top_bit[i] = 1'b1;
         end
      end
      onehot_ok = (fm_lm_vec != '0) &&
                  ((fm_lm_vec & (fm_lm_vec - CAM_LEN'(1))) == '0);
      chk_fail  = (state_q == EMIT) &&
                  (!onehot_ok || ((fm_lm_vec & ~pending_q) != '0) ||
                   (fm_lm_vec != top_bit));
   end

   // Sticky error flag, cleared by reset or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        err_q <= 1'b0;
      else if (flush)    err_q <= 1'b0;
      else if (chk_fail) err_q <= 1'b1;
   end

   assign onehot_err = err_q;
`else
   assign onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_sasa_match_sched.sv
// Directed bench for sasa_match_sched with a behavioural highest-match finder.
module tb_sasa_match_sched;

   localparam int unsigned CAM_LEN = 256;
   localparam int unsigned IDX_W   = 8;
   localparam int unsigned CNT_W   = 9;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [CAM_LEN-1:0] in_vec;
   logic               flush;
   logic [CAM_LEN-1:0] fm_or_vec;
   logic [CAM_LEN-1:0] fm_lm_vec;
   logic               out_valid;
   logic               out_ready;
   logic [IDX_W-1:0]   out_idx;
   logic               out_last;
   logic               done;
   logic [CNT_W-1:0]   match_cnt;
   logic               onehot_err;

   logic               ovr_en;
   logic [CAM_LEN-1:0] ovr_val;
   logic [CAM_LEN-1:0] v;

   int n_asserts = 0;
   int n_fail    = 0;

   sasa_match_sched dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_vec(in_vec), .flush(flush), .fm_or_vec(fm_or_vec),
      .fm_lm_vec(fm_lm_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last), .done(done),
      .match_cnt(match_cnt), .onehot_err(onehot_err)
   );

   always #5 clk = ~clk;

   function automatic logic [CAM_LEN-1:0] highest(input logic [CAM_LEN-1:0] x);
      logic [CAM_LEN-1:0] r;
      r = '0;
      for (int i = CAM_LEN - 1; i >= 0; i--) begin
         if (x[i]) begin
            r[i] = 1'b1;
            break;
         end
      end
      return r;
   endfunction

   // Finder model, with an override used to inject an inconsistent return
   always_comb fm_lm_vec = ovr_en ? ovr_val : highest(fm_or_vec);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [CAM_LEN-1:0] vec);
      in_vec   = vec;
      in_valid = 1'b1;
      chk("accept_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_vec   = '0;
   endtask

   task automatic beat(input string tag, input int idx, input logic last);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_idx"},   32'(out_idx),   32'(idx));
      chk({tag, "_last"},  32'(out_last),  32'(last));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; flush = 1'b0;
      out_ready = 1'b0; ovr_en = 1'b0; ovr_val = '0;
      #12;
      chk("rst_in_ready",  32'(in_ready),   32'd1);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      chk("rst_out_idx",   32'(out_idx),    32'd0);
      chk("rst_out_last",  32'(out_last),   32'd0);
      chk("rst_done",      32'(done),       32'd0);
      chk("rst_match_cnt", 32'(match_cnt),  32'd0);
      chk("rst_onehot",    32'(onehot_err), 32'd0);
      chk("rst_fm_or",     32'(|fm_or_vec), 32'd0);
      rst_n = 1'b1;
      tick();

      // Three matches, consumer always ready
      out_ready = 1'b1;
      v = '0; v[200] = 1'b1; v[37] = 1'b1; v[5] = 1'b1;
      accept(v);
      beat("t1_b0", 200, 1'b0);
      chk("t1_in_ready_emit", 32'(in_ready), 32'd0);
      tick(); beat("t1_b1", 37, 1'b0);
      tick(); beat("t1_b2", 5, 1'b1);
      tick();
      chk("t1_done",      32'(done),      32'd1);
      chk("t1_match_cnt", 32'(match_cnt), 32'd3);
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_in_ready",  32'(in_ready),  32'd0);
      tick();
      chk("t1_in_ready_back", 32'(in_ready),  32'd1);
      chk("t1_done_off",      32'(done),      32'd0);
      chk("t1_cnt_hold",      32'(match_cnt), 32'd3);

      // Zero vector: straight to done
      accept('0);
      chk("z_out_valid", 32'(out_valid), 32'd0);
      chk("z_done",      32'(done),      32'd1);
      chk("z_match_cnt", 32'(match_cnt), 32'd0);
      tick();
      chk("z_in_ready",  32'(in_ready),  32'd1);

      // Stalled first beat of {255,0}
      out_ready = 1'b0;
      v = '0; v[255] = 1'b1; v[0] = 1'b1;
      accept(v);
      for (int i = 0; i < 3; i++) begin
         beat("st_hold", 255, 1'b0);
         chk("st_pending_bit", 32'(fm_or_vec[255]), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      beat("st_b0", 255, 1'b0);
      tick(); beat("st_b1", 0, 1'b1);
      tick();
      chk("st_done",      32'(done),      32'd1);
      chk("st_match_cnt", 32'(match_cnt), 32'd2);
      tick();

      // Flush on the second beat of {10,9,8}, with a competing in_valid
      v = '0; v[10] = 1'b1; v[9] = 1'b1; v[8] = 1'b1;
      accept(v);
      beat("fl_b0", 10, 1'b0);
      tick();
      beat("fl_b1", 9, 1'b0);
      flush = 1'b1; in_valid = 1'b1; in_vec = '1;
      tick();
      flush = 1'b0; in_valid = 1'b0; in_vec = '0;
      chk("fl_in_ready",  32'(in_ready),   32'd1);
      chk("fl_done",      32'(done),       32'd0);
      chk("fl_out_valid", 32'(out_valid),  32'd0);
      chk("fl_pending",   32'(|fm_or_vec), 32'd0);
      chk("fl_cnt_hold",  32'(match_cnt),  32'd2);
      v = '0; v[3] = 1'b1;
      accept(v);
      beat("fl_next", 3, 1'b1);
      tick();
      chk("fl_next_done", 32'(done),      32'd1);
      chk("fl_next_cnt",  32'(match_cnt), 32'd1);
      tick();

      // All-ones vector: 256 beats, 255 down to 0
      accept('1);
      for (int i = 0; i < 256; i++) begin
         beat("ones", 255 - i, (i == 255));
         tick();
      end
      chk("ones_done",      32'(done),      32'd1);
      chk("ones_match_cnt", 32'(match_cnt), 32'd256);
      tick();

      // Inconsistent finder return (two bits) while pending = 0x3
      out_ready = 1'b0;
      accept(CAM_LEN'(3));
      ovr_val = CAM_LEN'(3);
      ovr_en  = 1'b1;
      tick();
`ifdef SASA_ONEHOT_CHK_EN
      chk("oh_set",  32'(onehot_err), 32'd1);
      tick();
      chk("oh_held", 32'(onehot_err), 32'd1);
`else
      chk("oh_tied", 32'(onehot_err), 32'd0);
      tick();
      chk("oh_tied2", 32'(onehot_err), 32'd0);
`endif
      chk("oh_still_emit", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0; ovr_en = 1'b0;
      chk("oh_cleared",  32'(onehot_err), 32'd0);
      chk("oh_idle",     32'(in_ready),   32'd1);

      // Asynchronous reset in the middle of a transaction
      out_ready = 1'b0;
      v = '0; v[7] = 1'b1;
      accept(v);
      chk("ar_emit", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid),  32'd0);
      chk("ar_in_ready",  32'(in_ready),   32'd1);
      chk("ar_pending",   32'(|fm_or_vec), 32'd0);
      chk("ar_match_cnt", 32'(match_cnt),  32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("ar_idle", 32'(in_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
